// File: rtl/hack_mem_fabric.sv
// hack_mem_fabric: data-memory fabric for the Hack platform.
// The UART host and the CPU data port share one slave bus, and the host has
// priority. The address is decoded into NUM_REGION base/end windows. Read data
// returns one cycle after the address, so a registered select steers it back to
// the master that issued the read. Any access that hits no window is logged in
// a sticky error register.
module hack_mem_fabric #(
  parameter int WIDTH      = 16,
  parameter int NUM_REGION = 3,
  parameter logic [NUM_REGION*WIDTH-1:0] REGION_BASE = {16'h6000, 16'h4000, 16'h0000},
  parameter logic [NUM_REGION*WIDTH-1:0] REGION_END  = {16'h6001, 16'h6000, 16'h4000},
  parameter int ERR_CW     = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  // CPU data port
  input  logic [WIDTH-1:0]            addressM,
  input  logic [WIDTH-1:0]            outM,
  input  logic                        writeM,
  output logic [WIDTH-1:0]            inM,
  output logic                        cpu_stall,
  // UART host port
  input  logic [WIDTH-1:0]            host_address,
  input  logic                        host_wvalid,
  input  logic [WIDTH-1:0]            host_wdata,
  output logic                        host_wready,
  input  logic                        host_rvalid,
  output logic                        host_rready,
  output logic                        host_rrvalid,
  output logic [WIDTH-1:0]            host_rdata,
  // slave bus
  output logic [WIDTH-1:0]            slv_addr,
  output logic [WIDTH-1:0]            slv_wdata,
  output logic [NUM_REGION-1:0]       slv_write,
  input  logic [NUM_REGION*WIDTH-1:0] slv_rdata,
  // error reporting
  input  logic                        err_clear,
  output logic                        err_valid,
  output logic [WIDTH-1:0]            err_addr,
  output logic                        err_src,
  output logic [ERR_CW-1:0]           err_count
);

  // arbitration and bus mux
  logic                  w_host_req;
  logic                  w_host_rd;
  logic                  w_rd;
  logic                  w_bus_write;
  logic [WIDTH-1:0]      w_bus_addr;
  logic [WIDTH-1:0]      w_bus_wdata;
  // decode
  logic [NUM_REGION-1:0] w_region_hit;
  logic [NUM_REGION-1:0] w_hit_oh;
  logic                  w_any_hit;
  logic [WIDTH-1:0]      w_offset;
  // read return
  logic [WIDTH-1:0]      w_rdata;
  logic                  r_sel_vld;
  logic                  r_sel_host;
  logic [NUM_REGION-1:0] r_sel_hit;
  logic [WIDTH-1:0]      r_inm_hold;
  logic [WIDTH-1:0]      r_hdata_hold;
  // error state
  logic                  w_invalid;
  logic                  w_capture;
  logic                  r_err_valid;
  logic [WIDTH-1:0]      r_err_addr;
  logic                  r_err_src;
  logic [ERR_CW-1:0]     r_err_count;

  // The host always owns the bus when it requests it. A host write beats a host read.
  assign w_host_req  = host_wvalid | host_rvalid;
  assign w_host_rd   = host_rvalid & ~host_wvalid;
  // Every unstalled CPU cycle counts as a read, as does a granted host read.
  assign w_rd        = ~w_host_req | w_host_rd;
  assign w_bus_addr  = w_host_req ? host_address : addressM;
  assign w_bus_wdata = w_host_req ? host_wdata : outM;
  assign w_bus_write = w_host_req ? host_wvalid : writeM;

  assign cpu_stall   = w_host_req;
  assign host_wready = host_wvalid;
  assign host_rready = w_host_rd;

  // Raw window compare for each region: base inclusive, end exclusive.
  always_comb begin
    w_region_hit = '0;
    for (int i = 0; i < NUM_REGION; i++) begin
      w_region_hit[i] = (w_bus_addr >= REGION_BASE[i*WIDTH +: WIDTH]) &&
                        (w_bus_addr <  REGION_END[i*WIDTH +: WIDTH]);
    end
  end

  // The lowest-indexed hit wins. The offset is taken from the winning base and is zero on a miss.
  always_comb begin : p_decode
    logic v_found;
    v_found  = 1'b0;
    w_hit_oh = '0;
    w_offset = '0;
    for (int i = 0; i < NUM_REGION; i++) begin
      w_hit_oh[i] = w_region_hit[i] & ~v_found;
      v_found     = v_found | w_region_hit[i];
      w_offset    = w_offset |
                    ({WIDTH{w_hit_oh[i]}} & (w_bus_addr - REGION_BASE[i*WIDTH +: WIDTH]));
    end
    w_any_hit = v_found;
  end

  assign slv_addr  = w_offset;
  assign slv_wdata = w_bus_wdata;
  // On a miss w_hit_oh is all zeros, so an invalid write never reaches a slave.
  assign slv_write = {NUM_REGION{w_bus_write}} & w_hit_oh;

  // Select the read data of the region recorded for the previous cycle. No region selected gives 0.
  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGION; i++) begin
      w_rdata = w_rdata | ({WIDTH{r_sel_hit[i]}} & slv_rdata[i*WIDTH +: WIDTH]);
    end
  end

  // Record who issued this cycle's read and which region it hit, so the data can be steered next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_vld  <= 1'b0;
      r_sel_host <= 1'b0;
      r_sel_hit  <= '0;
    end else begin
      r_sel_vld  <= w_rd;
      r_sel_host <= w_host_rd;
      r_sel_hit  <= w_rd ? w_hit_oh : {NUM_REGION{1'b0}};
    end
  end

  // While its master is not reading, each read-data port holds its last delivered value.
  assign inM          = (r_sel_vld & ~r_sel_host) ? w_rdata : r_inm_hold;
  assign host_rdata   = (r_sel_vld &  r_sel_host) ? w_rdata : r_hdata_hold;
  assign host_rrvalid = r_sel_vld & r_sel_host;

  // Keep the last value shown on each read-data port for the cycles where it has no new read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inm_hold   <= '0;
      r_hdata_hold <= '0;
    end else begin
      r_inm_hold   <= inM;
      r_hdata_hold <= host_rdata;
    end
  end

  // The bus always has an owner, so a decode miss is always an invalid access.
  assign w_invalid = ~w_any_hit;
  // Capture when nothing is latched yet, or when a clear makes room in the same cycle.
  assign w_capture = w_invalid & (~r_err_valid | err_clear);

  // Sticky error flag, first-error address/source and saturating error count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_valid <= 1'b0;
      r_err_addr  <= '0;
      r_err_src   <= 1'b0;
      r_err_count <= '0;
    end else begin
      if (w_invalid) begin
        r_err_valid <= 1'b1;
      end else if (err_clear) begin
        r_err_valid <= 1'b0;
      end else begin
        r_err_valid <= r_err_valid;
      end
      if (w_capture) begin
        r_err_addr <= w_bus_addr;
        r_err_src  <= w_host_req;
      end else begin
        r_err_addr <= r_err_addr;
        r_err_src  <= r_err_src;
      end
      if (w_invalid && (r_err_count != {ERR_CW{1'b1}})) begin
        r_err_count <= r_err_count + {{(ERR_CW-1){1'b0}}, 1'b1};
      end else begin
        r_err_count <= r_err_count;
      end
    end
  end

  assign err_valid = r_err_valid;
  assign err_addr  = r_err_addr;
  assign err_src   = r_err_src;
  assign err_count = r_err_count;

endmodule

// File: tb/tb_hack_mem_fabric.sv
// Bench for hack_mem_fabric with the default three-region map.
// The slaves are modelled as simple 1-cycle-latency RAMs. A table of bus
// cycles gives the expected combinational decode and the read data each cycle
// should return. That read data goes to a scoreboard queue and is compared one
// cycle later. Hand-written sequences cover the error register and async reset.
module tb_hack_mem_fabric;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addressM = 16'h0000, outM = 16'h0000, host_address = 16'h0000;
  logic [15:0] host_wdata = 16'h0000;
  logic        writeM = 1'b0, host_wvalid = 1'b0, host_rvalid = 1'b0, err_clear = 1'b0;
  logic [15:0] inM, host_rdata, slv_addr, slv_wdata, err_addr;
  logic        cpu_stall, host_wready, host_rready, host_rrvalid, err_valid, err_src;
  logic [2:0]  slv_write;
  logic [47:0] slv_rdata;
  logic [7:0]  err_count;

  int n_checks = 0;
  int n_errors = 0;

  hack_mem_fabric dut (
    .clk(clk), .rst_n(rst_n),
    .addressM(addressM), .outM(outM), .writeM(writeM), .inM(inM), .cpu_stall(cpu_stall),
    .host_address(host_address), .host_wvalid(host_wvalid), .host_wdata(host_wdata),
    .host_wready(host_wready), .host_rvalid(host_rvalid), .host_rready(host_rready),
    .host_rrvalid(host_rrvalid), .host_rdata(host_rdata),
    .slv_addr(slv_addr), .slv_wdata(slv_wdata), .slv_write(slv_write), .slv_rdata(slv_rdata),
    .err_clear(err_clear), .err_valid(err_valid), .err_addr(err_addr), .err_src(err_src),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Slave RAMs: data is read from the offset one cycle after it is presented (old data on
  // a simultaneous write). Each RAM is preloaded with a distinct pattern while in reset.
  logic [15:0] mem0 [256];
  logic [15:0] mem1 [256];
  logic [15:0] mem2 [256];
  logic [15:0] rd0, rd1, rd2;
  assign slv_rdata = {rd2, rd1, rd0};

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 256; k++) begin
        mem0[k] <= 16'h0100 + 16'(k);
        mem1[k] <= 16'hA000 + 16'(k);
        mem2[k] <= 16'hC000 + 16'(k);
      end
      rd0 <= 16'h0000;
      rd1 <= 16'h0000;
      rd2 <= 16'h0000;
    end else begin
      rd0 <= mem0[slv_addr[7:0]];
      rd1 <= mem1[slv_addr[7:0]];
      rd2 <= mem2[slv_addr[7:0]];
      if (slv_write[0]) mem0[slv_addr[7:0]] <= slv_wdata;
      if (slv_write[1]) mem1[slv_addr[7:0]] <= slv_wdata;
      if (slv_write[2]) mem2[slv_addr[7:0]] <= slv_wdata;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] addr;  logic [15:0] outm;   logic wm;
    logic [15:0] haddr; logic [15:0] hwdata; logic hw; logic hr;
    logic [2:0]  e_write; logic [15:0] e_saddr; logic e_stall;
    logic [15:0] e_rd;     // data the owner's read returns next cycle
  } vec_t;

  typedef struct {
    logic        host;     // host owned the bus in that cycle
    logic        rd;       // host read was granted
    logic [15:0] data;     // expected read data
    logic [15:0] hold;     // inM value expected while the CPU is stalled
  } sb_t;

  vec_t vq[$];
  sb_t  sb_q[$];
  logic [15:0] exp_inm = 16'h0000;

  task automatic add(input logic [15:0] a, input logic [15:0] o, input logic w,
                     input logic [15:0] ha, input logic [15:0] hd, input logic hw, input logic hr,
                     input logic [2:0] ew, input logic [15:0] es, input logic est,
                     input logic [15:0] erd);
    vec_t v;
    v.addr = a; v.outm = o; v.wm = w; v.haddr = ha; v.hwdata = hd; v.hw = hw; v.hr = hr;
    v.e_write = ew; v.e_saddr = es; v.e_stall = est; v.e_rd = erd;
    vq.push_back(v);
  endtask

  // Compare the read result of the previous cycle against the scoreboard.
  task automatic check_prev();
    sb_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.host) begin
        chk("host_rrvalid", 32'(host_rrvalid), 32'(e.rd));
        if (e.rd) chk("host_rdata", 32'(host_rdata), 32'(e.data));
        chk("inM_hold", 32'(inM), 32'(e.hold));
      end else begin
        chk("host_rrvalid_idle", 32'(host_rrvalid), 32'(1'b0));
        chk("inM", 32'(inM), 32'(e.data));
      end
    end
  endtask

  initial begin
    sb_t e;
    // CPU write then read back, one pair per region
    add(16'h0005, 16'h1234, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b001, 16'h0005, 1'b0, 16'h0105);
    add(16'h0005, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0005, 1'b0, 16'h1234);
    add(16'h4007, 16'hBEEF, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b010, 16'h0007, 1'b0, 16'hA007);
    add(16'h4007, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0007, 1'b0, 16'hBEEF);
    add(16'h6000, 16'h5A5A, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b100, 16'h0000, 1'b0, 16'hC000);
    add(16'h6000, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 16'h5A5A);
    // collision: host write wins, CPU write retried once the host goes idle
    add(16'h0010, 16'h1111, 1'b1, 16'h0020, 16'h2222, 1'b1, 1'b0, 3'b001, 16'h0020, 1'b1, 16'h0000);
    add(16'h0010, 16'h1111, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b001, 16'h0010, 1'b0, 16'h0110);
    add(16'h0020, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0020, 1'b0, 16'h2222);
    add(16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0010, 1'b0, 16'h1111);
    // back-to-back host reads from region 1 while the CPU is stalled
    for (int k = 0; k < 4; k++)
      add(16'h0010, 16'h0000, 1'b0, 16'h4000 + 16'(k), 16'h0000, 1'b0, 1'b1,
          3'b000, 16'(k), 1'b1, 16'hA000 + 16'(k));
    add(16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0010, 1'b0, 16'h1111);
    // invalid accesses: CPU write to a hole, host read of a hole
    add(16'h7000, 16'hDEAD, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0000, 1'b0, 16'h0000);
    add(16'h0010, 16'h0000, 1'b0, 16'h8000, 16'h0000, 1'b0, 1'b1, 3'b000, 16'h0000, 1'b1, 16'h0000);
    add(16'h0010, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 3'b000, 16'h0010, 1'b0, 16'h1111);

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_inM", 32'(inM), 32'(16'h0000));
    chk("rst_host_rdata", 32'(host_rdata), 32'(16'h0000));
    chk("rst_host_rrvalid", 32'(host_rrvalid), 32'(1'b0));
    chk("rst_err_valid", 32'(err_valid), 32'(1'b0));
    chk("rst_err_addr", 32'(err_addr), 32'(16'h0000));
    chk("rst_err_src", 32'(err_src), 32'(1'b0));
    chk("rst_err_count", 32'(err_count), 32'(8'h00));
    rst_n = 1'b1;

    // table-driven bus cycles
    foreach (vq[k]) begin
      @(posedge clk); #1;
      addressM = vq[k].addr; outM = vq[k].outm; writeM = vq[k].wm;
      host_address = vq[k].haddr; host_wdata = vq[k].hwdata;
      host_wvalid = vq[k].hw; host_rvalid = vq[k].hr;
      @(negedge clk);
      chk("slv_write", 32'(slv_write), 32'(vq[k].e_write));
      chk("slv_addr", 32'(slv_addr), 32'(vq[k].e_saddr));
      chk("cpu_stall", 32'(cpu_stall), 32'(vq[k].e_stall));
      chk("host_wready", 32'(host_wready), 32'(vq[k].hw));
      chk("host_rready", 32'(host_rready), 32'(vq[k].hr & ~vq[k].hw));
      check_prev();
      if (vq[k].hw | vq[k].hr) begin
        e.host = 1'b1; e.rd = vq[k].hr & ~vq[k].hw; e.data = vq[k].e_rd; e.hold = exp_inm;
      end else begin
        e.host = 1'b0; e.rd = 1'b0; e.data = vq[k].e_rd; e.hold = vq[k].e_rd;
        exp_inm = vq[k].e_rd;
      end
      sb_q.push_back(e);
    end
    // drain the last read and check the error log from the two invalid accesses
    @(posedge clk); #1;
    @(negedge clk);
    check_prev();
    chk("err_valid", 32'(err_valid), 32'(1'b1));
    chk("err_addr", 32'(err_addr), 32'(16'h7000));
    chk("err_src", 32'(err_src), 32'(1'b0));
    chk("err_count", 32'(err_count), 32'(8'd2));

    // err_clear together with a new host error at 16'h6001: the new error is captured
    @(posedge clk); #1;
    host_address = 16'h6001; host_rvalid = 1'b1; err_clear = 1'b1;
    @(negedge clk);
    chk("clr_slv_write", 32'(slv_write), 32'(3'b000));
    @(posedge clk); #1;
    host_rvalid = 1'b0; err_clear = 1'b0; addressM = 16'h6001;
    chk("clr_err_valid", 32'(err_valid), 32'(1'b1));
    chk("clr_err_addr", 32'(err_addr), 32'(16'h6001));
    chk("clr_err_src", 32'(err_src), 32'(1'b1));
    chk("clr_err_count", 32'(err_count), 32'(8'd3));
    chk("miss_rrvalid", 32'(host_rrvalid), 32'(1'b1));
    chk("miss_rdata", 32'(host_rdata), 32'(16'h0000));

    // saturate the counter with CPU misses; the first error stays latched
    repeat (260) @(posedge clk);
    #1;
    chk("sat_err_count", 32'(err_count), 32'(8'hFF));
    chk("sat_err_src", 32'(err_src), 32'(1'b1));
    @(posedge clk); #1;
    chk("sat_hold", 32'(err_count), 32'(8'hFF));

    // plain clear: flag drops, other error fields hold
    addressM = 16'h0010; err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    chk("clr2_err_valid", 32'(err_valid), 32'(1'b0));
    chk("clr2_err_addr", 32'(err_addr), 32'(16'h6001));
    chk("clr2_err_count", 32'(err_count), 32'(8'hFF));

    // async reset while a host read result is being returned
    host_address = 16'h4001; host_rvalid = 1'b1;
    @(posedge clk); #1;
    chk("pre_rst_rrvalid", 32'(host_rrvalid), 32'(1'b1));
    chk("pre_rst_rdata", 32'(host_rdata), 32'(16'hA001));
    chk("pre_rst_inM", 32'(inM), 32'(16'h1111));
    rst_n = 1'b0;
    #1;
    chk("arst_rrvalid", 32'(host_rrvalid), 32'(1'b0));
    chk("arst_inM", 32'(inM), 32'(16'h0000));
    chk("arst_host_rdata", 32'(host_rdata), 32'(16'h0000));
    chk("arst_err_valid", 32'(err_valid), 32'(1'b0));
    chk("arst_err_addr", 32'(err_addr), 32'(16'h0000));
    chk("arst_err_src", 32'(err_src), 32'(1'b0));
    chk("arst_err_count", 32'(err_count), 32'(8'h00));
    host_rvalid = 1'b0;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
